// File: rtl/hs_cdc_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hs_cdc_rx_if
// Description : Handshake bundle for the hs_cdc_rx receiver. Carries the
//               foreign-domain req/ack/data triplet and the local
//               valid/ready consumer channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface hs_cdc_rx_if #(
  parameter int N = 8
);
  // Sender (foreign clock domain) side
  logic         req_in;
  logic [N-1:0] data_in;
  logic         ack_out;
  // Local consumer side
  logic [N-1:0] data_out;
  logic         valid_out;
  logic         ready_in;

  // Environment view: drives the request and the consumer ready
  modport master (
    output req_in,
    output data_in,
    output ready_in,
    input  ack_out,
    input  data_out,
    input  valid_out
  );

  // Receiver view
  modport slave (
    input  req_in,
    input  data_in,
    input  ready_in,
    output ack_out,
    output data_out,
    output valid_out
  );
endinterface
`default_nettype wire

// File: rtl/hs_cdc_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hs_cdc_rx
// Description : Destination end of a four-phase req/ack clock-domain
//               crossing. Synchronizes the request, captures the bundled
//               data word, offers it to a local valid/ready consumer and
//               returns a registered acknowledge to the sender.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_cdc_rx #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  wire        clk,
  input  wire        rst_n,
  input  wire        ena,
  hs_cdc_rx_if.slave bus,
  output logic [7:0] xfer_cnt,
  output logic       proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [N-1:0]           data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ack_q, ack_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   perr_q, perr_d;

  // Request synchronizer: req_in shifts in at bit 0, the oldest sample is req_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_in};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= 8'd0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state and next-output logic. data_in is only looked at once req_s
  // is high, at which point the sender guarantees it has been stable for
  // the whole synchronizer latency.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    case (state_q)
      ST_IDLE: begin
        // ena only gates new requests; it never aborts one in flight
        if (ena && req_s) begin
          data_d  = bus.data_in;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // req_s was high on entry, so seeing it low here means the sender
        // withdrew before being acknowledged. Flag it and carry on.
        if (!req_s) begin
          perr_d = 1'b1;
        end
        if (bus.ready_in) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        ack_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.ack_out   = ack_q;
  assign xfer_cnt      = cnt_q;
  assign proto_err     = perr_q;

endmodule
`default_nettype wire

// File: doc/hs_cdc_rx.md
# hs_cdc_rx

Destination end of the four-phase req/ack CDC handshake in the synchronizer test chip. Complements the pulse and toggle synchronizers, which only move data forward. The block sits in the `clk` domain and accepts a request plus bundled data from a foreign clock domain. It synchronizes the request, captures the data, presents it to a local consumer with valid/ready, and returns a registered acknowledge to the sender.

## Interface
Parameters:
- `N`, 8, width of the bundled data word.
- `SYNC_STAGES`, 2, flip-flops in the `req_in` synchronizer chain; legal range 2..4.

Ports:
- `clk` in 1: local clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: block enable; gates acceptance of new requests only.
- `req_in` in 1: asynchronous request from the sender domain.
- `data_in` in N: asynchronous data. The sender holds it stable from before `req_in` rises until `ack_out` is seen high.
- `ack_out` out 1: registered acknowledge to the sender domain.
- `data_out` out N: captured word.
- `valid_out` out 1: `data_out` is valid.
- `ready_in` in 1: consumer accepts `data_out`.
- `xfer_cnt` out 8: count of completed local transfers.
- `proto_err` out 1: sticky sender-protocol violation flag.

## Operation
- **Synchronizer.** `req_in` passes through a `SYNC_STAGES`-deep flop chain; the last stage is `req_s`.
- **`data_in`.** Never synchronized. It is sampled only when `req_s` is high, which relies on the bundled-data stability rule above.
- **FSM states:** IDLE, PRESENT, ACK.
- **IDLE** (`ack_out`=0, `valid_out`=0):
  - `req_s`=1 and `ena`=1 → `data_out` ← `data_in`, `valid_out` ← 1, go to PRESENT.
  - `ena`=0 → `req_s` is ignored and the FSM stays in IDLE.
- **PRESENT** (`valid_out`=1):
  - `data_out` and `valid_out` are held until a cycle with `ready_in`=1.
  - At that edge: `valid_out` ← 0, `ack_out` ← 1, `xfer_cnt` ← `xfer_cnt`+1, go to ACK.
- **ACK** (`ack_out`=1): hold until `req_s`=0, then `ack_out` ← 0, go to IDLE.
- **No early drop.** `valid_out` never falls without a handshake, and `data_out` never changes while `valid_out`=1.
- **`data_out` retention.** It keeps the last captured word after `valid_out` falls; it is not cleared.
- **`ena` mid-transfer.** Deasserting `ena` in PRESENT or ACK does not abort; the transaction completes.
- **`xfer_cnt`.** 8-bit, wraps 255→0 with no flag.
- **`proto_err`.**
  - Set when `req_s` falls while in PRESENT, i.e. the sender withdrew before `ack_out`.
  - The FSM continues normally: after `ready_in`, it enters ACK, sees `req_s`=0, and returns to IDLE. `ack_out` therefore pulses for exactly 1 cycle.
  - Cleared only by reset.
- **Reset values:** sync chain 0, state IDLE, `ack_out` 0, `valid_out` 0, `data_out` 0, `xfer_cnt` 0, `proto_err` 0.
- **Reset mid-operation.** All of the above take effect immediately (asynchronous), including a drop of `ack_out` while the sender still holds `req_in`. After reset release, a still-high `req_in` is treated as a new request.

## Timing
- Edge numbering: let edge k be the first `clk` rising edge that samples `req_in`=1.
  - `req_s`=1 after edge k+`SYNC_STAGES`-1.
  - `valid_out`=1 and `data_out` updated after edge k+`SYNC_STAGES`.
- With `ready_in` held 1: `ack_out`=1 after edge k+`SYNC_STAGES`+1, one cycle after `valid_out` rises. There are no bubble cycles.
- `ack_out` fall: with edge j the first edge sampling `req_in`=0, `ack_out`=0 after edge j+`SYNC_STAGES`.
- Back-to-back requests: a new request seen in IDLE is accepted at the first edge in IDLE with `req_s`=1.
- Minimum round trip, in local cycles, ignoring sender-side latency: 2×`SYNC_STAGES`+2.
- Simultaneous `req_s` fall and `ready_in`=1 in PRESENT:
  - `proto_err` is set.
  - The transfer completes and is counted.
  - Next state is ACK, which exits on the following edge.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-PRESENT → all outputs 0 immediately; after release with `req_in`=0, state IDLE, no `valid_out`.
- **Basic transfer.** `SYNC_STAGES`=2, `ready_in`=1, `data_in`=0xA5, `req_in` rises before edge k → `valid_out`=1 and `data_out`=0xA5 after edge k+2; `ack_out`=1 after k+3. Then drop `req_in` → `ack_out`=0 two edges later; `xfer_cnt`=1.
- **Backpressure.** `ready_in`=0 for 5 cycles → `valid_out` and `data_out` stable and `ack_out`=0 throughout. Raise `ready_in` → `ack_out`=1 after the next edge.
- **Enable gating.** `ena`=0 with `req_in`=1 → no `valid_out` for 10 cycles. Raise `ena` → capture on the next edge.
- **Protocol violation.** Drop `req_in` while `valid_out`=1 and `ready_in`=0 → `proto_err`=1 and stays set. After `ready_in`, `ack_out` high exactly 1 cycle, then IDLE.
- **Counter wrap.** 256 back-to-back transfers with random data and random `ready_in` delays, plus `SYNC_STAGES`=3 with an asynchronous sender clock → every word received in order, `xfer_cnt` 255→0, `proto_err` stays 0.
